// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the line-granular data memory responder.
package data_memory_responder_pkg;
  localparam int LINE_W          = 256;
  localparam int OFFSET_W        = 5;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_line_array.sv
// Single-port DEPTH x LINE_W line store: synchronous write, synchronous registered read.
// The read register clears on reset; the array itself is never reset.
module dmem_line_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);
  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Holds its value across writes so the last read line stays visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency line memory responder: accepts one request from IDLE, counts LATENCY
// cycles, performs the array access on the edge entering ACK and pulses ack for one cycle.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_ack_o
);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;

  logic              arr_we, arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [LINE_W-1:0] arr_wdata;
  logic [IDX_W-1:0]  in_idx;
  logic              unused_addr;

  assign in_idx      = mem_addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
  assign unused_addr = ^{mem_addr_i[31:OFFSET_W+IDX_W], mem_addr_i[OFFSET_W-1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_idx   = idx_q;
    arr_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_enable_i) begin
          idx_d   = in_idx;
          wr_d    = mem_write_i;
          wdata_d = mem_data_i;
          cnt_d   = LAT_M1;
          // Single-cycle latency has no BUSY phase, so access straight from the inputs.
          if (LATENCY == 1) begin
            state_d   = ACK;
            ack_d     = 1'b1;
            arr_idx   = in_idx;
            arr_wdata = mem_data_i;
            arr_we    = mem_write_i;
            arr_re    = ~mem_write_i;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ACK;
          ack_d   = 1'b1;
          arr_we  = wr_q;
          arr_re  = ~wr_q;
        end
      end
      ACK: begin
        // No acceptance here: the initiator needs one cycle to drop its enable.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk_i) begin
    idx_q   <= idx_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  dmem_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (arr_we & ~rst_i),
    .re_i    (arr_re),
    .idx_i   (arr_idx),
    .wdata_i (arr_wdata),
    .rdata_o (mem_data_o)
  );

  assign mem_ack_o = ack_q;
endmodule
